quire_accum: RTL and testbench
==============================

// Module: quire_accum
// PURPOSE
//  Parametrised posit quire: accumulates signed posit terms (decoded values or exact products) into a two's-complement
//  fixed-point quire over sow..eow windows. Sits downstream of the decoder/multiplier and upstream of quire-to-posit.
//  Generalises the fixed posit(4,0) quire to posit(N,ES). Adds sticky NaR per window, overflow flag, end-of-window emit.
// PARAMETERS
//  POSIT_WIDTH   8   posit width N (>=4)
//  ES            0   posit exponent size
//  LOG_NB_ACCUM  10  carry-guard bits added to the minimum quire
//  IS_PROD_ACCUM 1   1: terms are exact products (mant in [1,4)); 0: plain posits (mant in [1,2))
//  EMIT_EOW      1   1: one output beat per window, on eow; 0: running value emitted every accepted beat
//  Derived (package): MAXSCALE=2^ES*(N-2); NQMIN=2^(ES+2)*(N-2)+1; QUIRE_SIZE=NQMIN+LOG_NB_ACCUM; BPP=(NQMIN-1)/2
//  MANT_W=(1+IS_PROD)*(N-ES-2); FBITS=MANT_W-1-IS_PROD; SCALE_W=$clog2((1+IS_PROD)*MAXSCALE+1)+1
// PORTS
//  clk      in  1           clock
//  rst_n    in  1           reset rst_n, asynchronous, active-low
//  rts_i    in  1           upstream ready-to-send
//  rtr_o    out 1           ready-to-receive, registered
//  sow_i    in  1           first term of window
//  eow_i    in  1           last term of window
//  mant_i   in  MANT_W      unsigned mantissa incl. hidden bit(s), value = mant_i*2^(scale_i-FBITS)
//  scale_i  in  SCALE_W     signed scale
//  sign_i   in  1           term sign
//  zero_i   in  1           term is zero (mant/scale ignored)
//  NaR_i    in  1           term is NaR
//  rtr_i    in  1           downstream ready
//  rts_o    out 1           output valid
//  sow_o    out 1           sow of emitted beat (EMIT_EOW=1: always 1)
//  eow_o    out 1           eow of emitted beat (EMIT_EOW=1: always 1)
//  data_o   out QUIRE_SIZE  quire, LSB weight 2^-BPP; 0 when NaR_o
//  NaR_o    out 1           window contained a NaR
//  sign_o   out 1           data_o MSB
//  zero_o   out 1           data_o == 0
//  ovf_o    out 1           signed add overflowed in this window (sticky)
// BEHAVIOUR
//  - Reset: all outputs 0 incl. rtr_o; rtr_o=1 on 2nd clk edge after release. Reset mid-window discards window.
//  - process_en = rtr_i | ~rts_o. rtr_o <= process_en each cycle. Accept = rts_i & rtr_o.
//  - Skid: a beat accepted while ~process_en is held in a 1-entry latch and consumed first once process_en=1; no loss.
//  - Stage 1 (align): sh = BPP+scale-FBITS; sh>=0: term=mant<<sh, else mant>>-sh (truncate). Zero -> term 0.
//  - Stage 2 (accumulate): start = sow | first beat after an eow | first beat after reset. On start: Q=±term, nar=NaR_i,
//    ovf=0. Else Q=Q±term (modulo 2^QUIRE_SIZE); ovf|=signed overflow; nar|=NaR_i. sow&eow same beat = 1-term window.
//  - Latency: accepted beat -> rts_o 2 cycles later with no backpressure; stall freezes both stages, clear on bubble.
//  - EMIT_EOW=1: non-eow beats update Q but never raise rts_o; EMIT_EOW=0: every beat emits running Q, sow/eow passed.
//  - Output holds until rtr_i & rts_o. NaR window: NaR_o=1, data_o=0, zero_o=1, ovf_o=0.
//  - Overflow keeps wrapped two's-complement value; ovf_o set on emitted beat.
// STRUCTURE
//  - posit_defines: functions for MAXSCALE, NQMIN, QUIRE_SIZE, BPP, MANT_W, FBITS, SCALE_W.
//  - Sub-module quire_align: combinational bidirectional shifter (mant,scale -> QUIRE_SIZE term).
//  - Top: skid latch, 2-stage pipe with staged/en/clr control, accumulator + sticky flags.
// TESTING (N=8, ES=0, IS_PROD=0, LOG_NB_ACCUM=4: QUIRE_SIZE=29, BPP=12, FBITS=5)
//  1. Window {+1.0 (mant=6'h20,s=0), +1.0, -0.5 (s=-1)} -> one beat, data_o=29'h1800, eow_o=1, 3rd beat +2 cycles.
//  2. Single beat sow&eow, +minpos (mant=6'h20,s=-6) -> data_o=29'h40; zero_i beat sow&eow -> data_o=0, zero_o=1.
//  3. Window {+1.0, NaR, +1.0} then window {+1.0} -> NaR_o=1, data_o=0; next window data_o=29'h1000, NaR_o=0.
//  4. 1024 beats of +64.0 (mant=6'h20,s=6), sow first, eow last -> data_o=29'h1000_0000, ovf_o=1.
//  5. rtr_i toggled randomly, rts_i held 1, 200-beat random windows -> results match golden model, no lost beat.
//  6. EMIT_EOW=0: {+1.0 sow, +1.0 eow} -> two beats 29'h1000, 29'h2000; rst_n low mid-window -> all outputs 0.

Source files
------------

// File: rtl/quire_accum_pkg.sv
// Shared sizing helpers for the posit quire accumulator.
// All quire geometry derives from the posit format (N, ES) and
// from whether the incoming terms are plain posits or exact products.
package quire_accum_pkg;

  // Flags that travel with one input term.
  typedef struct packed {
    logic sign;
    logic zero;
    logic nar;
    logic sow;
    logic eow;
  } beat_flags_t;

  // Largest scale of a posit(N,ES) value: useed^(N-2).
  function automatic int maxscale(input int n, input int es);
    return (1 << es) * (n - 2);
  endfunction

  // Minimum quire width that holds any exact product sum without carry guard.
  function automatic int nqmin(input int n, input int es);
    return (1 << (es + 2)) * (n - 2) + 1;
  endfunction

  function automatic int quire_size(input int n, input int es, input int log_nb_accum);
    return nqmin(n, es) + log_nb_accum;
  endfunction

  // Number of fractional bits in the quire (weight of LSB is 2^-BPP).
  function automatic int bpp(input int n, input int es);
    return (nqmin(n, es) - 1) / 2;
  endfunction

  // Mantissa width including hidden bit(s); products carry two integer bits.
  function automatic int mant_w(input int n, input int es, input int is_prod);
    return (1 + is_prod) * (n - es - 2);
  endfunction

  function automatic int fbits(input int n, input int es, input int is_prod);
    return mant_w(n, es, is_prod) - 1 - is_prod;
  endfunction

  // Signed scale width able to cover +/-(1+is_prod)*MAXSCALE.
  function automatic int scale_w(input int n, input int es, input int is_prod);
    return $clog2((1 + is_prod) * maxscale(n, es) + 1) + 1;
  endfunction

endpackage

// File: rtl/quire_accum_align.sv
// Combinational bidirectional shifter placing a term at its quire position.
// term = mant * 2^(BPP + scale - FBITS); right shifts truncate toward zero.
module quire_align #(
  parameter int QUIRE_SIZE = 29,
  parameter int MANT_W     = 6,
  parameter int SCALE_W    = 4,
  parameter int BPP        = 12,
  parameter int FBITS      = 5
) (
  input  logic                      [MANT_W-1:0]     mant,
  input  logic signed               [SCALE_W-1:0]    scale,
  input  logic                                       zero,
  output logic                      [QUIRE_SIZE-1:0] term
);

  localparam int SH_W = 16;

  logic signed [SH_W-1:0]       sh;
  logic        [SH_W-1:0]       sh_mag;
  logic        [QUIRE_SIZE-1:0] mant_ext;

  // Shift distance is signed: positive moves left, negative moves right.
  always_comb begin
    sh       = SH_W'(scale) + SH_W'(BPP - FBITS);
    mant_ext = QUIRE_SIZE'(mant);
    term     = '0;
    sh_mag   = '0;
    if (!zero) begin
      if (sh < 0) begin
        sh_mag = $unsigned(-sh);
        term   = mant_ext >> sh_mag;
      end else begin
        sh_mag = $unsigned(sh);
        term   = mant_ext << sh_mag;
      end
    end
  end

endmodule

// File: rtl/quire_accum.sv
// Posit quire accumulator: aligns signed posit terms into a fixed-point
// two's-complement quire and sums them over sow..eow windows, with a sticky
// NaR flag, a sticky signed-overflow flag and a one-entry skid latch so that
// the registered rtr_o never loses a beat.
module quire_accum
  import quire_accum_pkg::*;
#(
  parameter int  POSIT_WIDTH   = 8,
  parameter int  ES            = 0,
  parameter int  LOG_NB_ACCUM  = 10,
  parameter int  IS_PROD_ACCUM = 1,
  parameter int  EMIT_EOW      = 1,
  localparam int QUIRE_SIZE    = quire_size(POSIT_WIDTH, ES, LOG_NB_ACCUM),
  localparam int MANT_W        = mant_w(POSIT_WIDTH, ES, IS_PROD_ACCUM),
  localparam int SCALE_W       = scale_w(POSIT_WIDTH, ES, IS_PROD_ACCUM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rts_i,
  output logic                         rtr_o,
  input  logic                         sow_i,
  input  logic                         eow_i,
  input  logic        [MANT_W-1:0]     mant_i,
  input  logic signed [SCALE_W-1:0]    scale_i,
  input  logic                         sign_i,
  input  logic                         zero_i,
  input  logic                         NaR_i,
  input  logic                         rtr_i,
  output logic                         rts_o,
  output logic                         sow_o,
  output logic                         eow_o,
  output logic        [QUIRE_SIZE-1:0] data_o,
  output logic                         NaR_o,
  output logic                         sign_o,
  output logic                         zero_o,
  output logic                         ovf_o
);

  localparam int   BPP      = bpp(POSIT_WIDTH, ES);
  localparam int   FBITS    = fbits(POSIT_WIDTH, ES, IS_PROD_ACCUM);
  localparam int   MSB      = QUIRE_SIZE - 1;
  localparam logic EMIT_ALL = (EMIT_EOW == 0);

  typedef logic signed [QUIRE_SIZE-1:0] quire_t;

  // Modulo-2^QUIRE_SIZE add returning {signed_overflow, sum}.
  function automatic logic [QUIRE_SIZE:0] add_chk(input quire_t a, input quire_t b);
    quire_t s;
    s = a + b;
    return {(a[MSB] == b[MSB]) && (s[MSB] != a[MSB]), s};
  endfunction

  logic                      process_en;
  logic                      accept;
  logic                      rst_done;

  logic                      skid_vld;
  logic        [MANT_W-1:0]  skid_mant;
  logic signed [SCALE_W-1:0] skid_scale;
  beat_flags_t               skid_flags;

  logic                      vld_p0;
  logic        [MANT_W-1:0]  mant_p0;
  logic signed [SCALE_W-1:0] scale_p0;
  beat_flags_t               flags_p0;
  logic [QUIRE_SIZE-1:0]     term_p0;

  logic                      vld_p1;
  logic [QUIRE_SIZE-1:0]     term_p1;
  logic                      sign_p1;
  logic                      nar_p1;
  logic                      sow_p1;
  logic                      eow_p1;

  logic                      start_p1;
  quire_t                    addend_p1;
  quire_t                    base_p1;
  quire_t                    q_next_p1;
  logic                      ovf_step_p1;
  logic                      ovf_next_p1;
  logic                      nar_next_p1;
  logic                      emit_p1;

  quire_t                    q_p2;
  logic                      nar_p2;
  logic                      ovf_p2;
  logic                      win_open;

  assign process_en = rtr_i | ~rts_o;
  assign accept     = rts_i & rtr_o;

  // rtr_o follows process_en one cycle late, held low for one extra edge after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      rtr_o    <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      rtr_o    <= process_en & rst_done;
    end
  end

  // Skid occupancy: a beat caught during a stall waits here until the pipe moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          skid_vld <= 1'b0;
    else if (process_en) skid_vld <= 1'b0;
    else if (accept)     skid_vld <= 1'b1;
  end

  // Skid payload capture.
  always_ff @(posedge clk) begin
    if (!process_en && accept) begin
      skid_mant  <= mant_i;
      skid_scale <= scale_i;
      skid_flags <= '{sign: sign_i, zero: zero_i, nar: NaR_i, sow: sow_i, eow: eow_i};
    end
  end

  // Stage 0: pick the parked skid beat ahead of the live input.
  always_comb begin
    vld_p0 = skid_vld | accept;
    if (skid_vld) begin
      mant_p0  = skid_mant;
      scale_p0 = skid_scale;
      flags_p0 = skid_flags;
    end else begin
      mant_p0  = mant_i;
      scale_p0 = scale_i;
      flags_p0 = '{sign: sign_i, zero: zero_i, nar: NaR_i, sow: sow_i, eow: eow_i};
    end
  end

  quire_align #(
    .QUIRE_SIZE (QUIRE_SIZE),
    .MANT_W     (MANT_W),
    .SCALE_W    (SCALE_W),
    .BPP        (BPP),
    .FBITS      (FBITS)
  ) u_align (
    .mant  (mant_p0),
    .scale (scale_p0),
    .zero  (flags_p0.zero),
    .term  (term_p0)
  );

  // ---- stage 1 boundary: aligned term ----
  // Stage 1 valid: advances only when the pipe is not stalled; bubbles clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          vld_p1 <= 1'b0;
    else if (process_en) vld_p1 <= vld_p0;
  end

  // Stage 1 payload.
  always_ff @(posedge clk) begin
    if (process_en && vld_p0) begin
      term_p1 <= term_p0;
      sign_p1 <= flags_p0.sign;
      nar_p1  <= flags_p0.nar;
      sow_p1  <= flags_p0.sow;
      eow_p1  <= flags_p0.eow;
    end
  end

  // Accumulate: a window restarts on sow, after an eow, or after reset.
  always_comb begin
    start_p1    = sow_p1 | ~win_open;
    addend_p1   = sign_p1 ? -term_p1 : term_p1;
    base_p1     = start_p1 ? '0 : q_p2;
    {ovf_step_p1, q_next_p1} = add_chk(base_p1, addend_p1);
    ovf_next_p1 = ovf_step_p1 | (~start_p1 & ovf_p2);
    nar_next_p1 = nar_p1 | (~start_p1 & nar_p2);
    emit_p1     = vld_p1 & (eow_p1 | EMIT_ALL);
  end

  // ---- stage 2 boundary: quire and output beat ----
  // Quire and sticky flags update on every beat leaving stage 1.
  always_ff @(posedge clk) begin
    if (process_en && vld_p1) begin
      q_p2   <= q_next_p1;
      nar_p2 <= nar_next_p1;
      ovf_p2 <= ovf_next_p1;
    end
  end

  // Window tracking and output register; output holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_open <= 1'b0;
      rts_o    <= 1'b0;
      sow_o    <= 1'b0;
      eow_o    <= 1'b0;
      data_o   <= '0;
      NaR_o    <= 1'b0;
      sign_o   <= 1'b0;
      zero_o   <= 1'b0;
      ovf_o    <= 1'b0;
    end else if (process_en) begin
      rts_o <= emit_p1;
      if (vld_p1) win_open <= ~eow_p1;
      if (emit_p1) begin
        sow_o  <= EMIT_ALL ? sow_p1 : 1'b1;
        eow_o  <= EMIT_ALL ? eow_p1 : 1'b1;
        NaR_o  <= nar_next_p1;
        data_o <= nar_next_p1 ? '0 : q_next_p1;
        sign_o <= ~nar_next_p1 & q_next_p1[MSB];
        zero_o <= nar_next_p1 | (q_next_p1 == '0);
        ovf_o  <= ~nar_next_p1 & ovf_next_p1;
      end
    end
  end

endmodule

// File: tb/tb_quire_accum.sv
`timescale 1ns/1ps
module tb_quire_accum;

  localparam int     BPP   = 12;
  localparam int     FBITS = 5;
  localparam longint QMAX  = 64'sd268435455;
  localparam longint QMIN  = -64'sd268435456;
  localparam longint QSPAN = 64'sd536870912;

  typedef struct {
    bit sow; bit eow; bit sign; bit zero; bit nar;
    int mant; int scale;
  } beat_t;

  typedef struct {
    logic [28:0] data;
    logic nar; logic ovf; logic zero; logic sign; logic sow; logic eow;
    int cyc;
  } obeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rts_i = 1'b0, sow_i = 1'b0, eow_i = 1'b0, sign_i = 1'b0, zero_i = 1'b0, NaR_i = 1'b0;
  logic [5:0] mant_i = '0;
  logic signed [3:0] scale_i = '0;
  logic rtr_hold = 1'b1, rtr_rand = 1'b0, rtr_rnd = 1'b1;
  logic rtr_i;

  logic rtr_o, rts_o, sow_o, eow_o, NaR_o, sign_o, zero_o, ovf_o;
  logic [28:0] data_o;
  logic rtr_o0, rts_o0, sow_o0, eow_o0, NaR_o0, sign_o0, zero_o0, ovf_o0;
  logic [28:0] data_o0;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_acc_cyc = 0;
  obeat_t out_q[$];
  obeat_t out0_q[$];

  assign rtr_i = rtr_rand ? rtr_rnd : rtr_hold;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    rtr_rnd <= 1'($urandom_range(0, 1));
  end

  quire_accum #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(4), .IS_PROD_ACCUM(0), .EMIT_EOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o), .sow_i(sow_i), .eow_i(eow_i),
    .mant_i(mant_i), .scale_i(scale_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(NaR_i),
    .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o), .data_o(data_o),
    .NaR_o(NaR_o), .sign_o(sign_o), .zero_o(zero_o), .ovf_o(ovf_o)
  );

  quire_accum #(.POSIT_WIDTH(8), .ES(0), .LOG_NB_ACCUM(4), .IS_PROD_ACCUM(0), .EMIT_EOW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rts_i(rts_i), .rtr_o(rtr_o0), .sow_i(sow_i), .eow_i(eow_i),
    .mant_i(mant_i), .scale_i(scale_i), .sign_i(sign_i), .zero_i(zero_i), .NaR_i(NaR_i),
    .rtr_i(rtr_i), .rts_o(rts_o0), .sow_o(sow_o0), .eow_o(eow_o0), .data_o(data_o0),
    .NaR_o(NaR_o0), .sign_o(sign_o0), .zero_o(zero_o0), .ovf_o(ovf_o0)
  );

  // Output beats are captured on the falling edge preceding the handshake edge.
  always @(negedge clk) begin
    obeat_t o;
    if (rst_n && rts_o && rtr_i) begin
      o.data = data_o; o.nar = NaR_o; o.ovf = ovf_o; o.zero = zero_o;
      o.sign = sign_o; o.sow = sow_o; o.eow = eow_o; o.cyc = cyc;
      out_q.push_back(o);
    end
    if (rst_n && rts_o0 && rtr_i) begin
      o.data = data_o0; o.nar = NaR_o0; o.ovf = ovf_o0; o.zero = zero_o0;
      o.sign = sign_o0; o.sow = sow_o0; o.eow = eow_o0; o.cyc = cyc;
      out0_q.push_back(o);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk(input bit sow, input bit eow, input bit sign, input int mant,
                               input int scale, input bit zero, input bit nar);
    beat_t b;
    b.sow = sow; b.eow = eow; b.sign = sign; b.mant = mant; b.scale = scale;
    b.zero = zero; b.nar = nar;
    return b;
  endfunction

  // Reference: exact value of each term in quire LSB units, summed with wraparound.
  task automatic model_window(input beat_t w[$], output logic [28:0] d, output bit nar, output bit ovf);
    longint acc, t;
    int sh;
    acc = 0; nar = 0; ovf = 0;
    foreach (w[i]) begin
      t = 0;
      if (w[i].nar) nar = 1;
      if (!w[i].zero) begin
        sh = BPP + w[i].scale - FBITS;
        if (sh >= 0) t = longint'(w[i].mant) * (64'sd1 << sh);
        else         t = longint'(w[i].mant) / (64'sd1 << (-sh));
      end
      acc = w[i].sign ? acc - t : acc + t;
      if (acc > QMAX) begin ovf = 1; acc = acc - QSPAN; end
      if (acc < QMIN) begin ovf = 1; acc = acc + QSPAN; end
    end
    d = nar ? 29'd0 : acc[28:0];
    if (nar) ovf = 0;
  endtask

  task automatic send_beat(input beat_t b);
    int n;
    bit acc;
    rts_i = 1'b1; sow_i = b.sow; eow_i = b.eow; sign_i = b.sign;
    zero_i = b.zero; NaR_i = b.nar; mant_i = 6'(b.mant); scale_i = 4'(b.scale);
    n = 0; acc = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = rtr_o;
      last_acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    rts_i = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout: rtr_o=%b after %0d cycles, required 1", rtr_o, n);
    end
  endtask

  task automatic wait_outs(input int n, input bit use0, output bit ok);
    int c;
    c = 0;
    while (((use0 ? out0_q.size() : out_q.size()) < n) && c < 4000) begin
      @(posedge clk);
      c++;
    end
    ok = ((use0 ? out0_q.size() : out_q.size()) >= n);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rtr_o, rts_o, sow_o, eow_o, data_o, NaR_o, sign_o, zero_o, ovf_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rtr=%b rts=%b data=%h nar=%b zero=%b ovf=%b, required all 0",
               rtr_o, rts_o, data_o, NaR_o, zero_o, ovf_o);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rtr_o !== 1'b0) begin
      errors++; $display("FAIL rtr_first_edge: rtr_o=%b, required 0", rtr_o);
    end
    @(posedge clk); #1;
    checks++;
    if (rtr_o !== 1'b1) begin
      errors++; $display("FAIL rtr_second_edge: rtr_o=%b, required 1", rtr_o);
    end
  endtask

  task automatic test_window();
    bit ok;
    out_q.delete();
    send_beat(mk(1, 0, 0, 32, 0, 0, 0));
    send_beat(mk(0, 0, 0, 32, 0, 0, 0));
    send_beat(mk(0, 1, 1, 32, -1, 0, 0));
    wait_outs(1, 0, ok);
    checks++;
    if (out_q.size() != 1) begin
      errors++; $display("FAIL window_beats: got %0d beats, required 1", out_q.size());
    end
    if (ok) begin
      checks++;
      if (out_q[0].data !== 29'h1800) begin
        errors++; $display("FAIL window_data: got %h, required 00001800", out_q[0].data);
      end
      checks++;
      if (out_q[0].eow !== 1'b1 || out_q[0].sow !== 1'b1 || out_q[0].nar !== 1'b0) begin
        errors++; $display("FAIL window_flags: sow=%b eow=%b nar=%b, required 1 1 0",
                           out_q[0].sow, out_q[0].eow, out_q[0].nar);
      end
      checks++;
      if (out_q[0].cyc - last_acc_cyc != 2) begin
        errors++; $display("FAIL window_latency: got %0d cycles, required 2", out_q[0].cyc - last_acc_cyc);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    out_q.delete();
    send_beat(mk(1, 1, 0, 32, -6, 0, 0));
    send_beat(mk(1, 1, 0, 45, 3, 1, 0));
    wait_outs(2, 0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL single_beats: got %0d beats, required 2", out_q.size());
    end else begin
      checks++;
      if (out_q[0].data !== 29'h40 || out_q[0].zero !== 1'b0) begin
        errors++; $display("FAIL single_minpos: data=%h zero=%b, required 00000040 0",
                           out_q[0].data, out_q[0].zero);
      end
      checks++;
      if (out_q[1].data !== 29'h0 || out_q[1].zero !== 1'b1 || out_q[1].sign !== 1'b0) begin
        errors++; $display("FAIL single_zero: data=%h zero=%b sign=%b, required 0 1 0",
                           out_q[1].data, out_q[1].zero, out_q[1].sign);
      end
    end
  endtask

  task automatic test_nar();
    bit ok;
    out_q.delete();
    send_beat(mk(1, 0, 0, 32, 0, 0, 0));
    send_beat(mk(0, 0, 0, 17, 2, 0, 1));
    send_beat(mk(0, 1, 0, 32, 0, 0, 0));
    send_beat(mk(1, 1, 0, 32, 0, 0, 0));
    wait_outs(2, 0, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL nar_beats: got %0d beats, required 2", out_q.size());
    end else begin
      checks++;
      if (out_q[0].nar !== 1'b1 || out_q[0].data !== 29'h0 || out_q[0].zero !== 1'b1 || out_q[0].ovf !== 1'b0) begin
        errors++; $display("FAIL nar_window: nar=%b data=%h zero=%b ovf=%b, required 1 0 1 0",
                           out_q[0].nar, out_q[0].data, out_q[0].zero, out_q[0].ovf);
      end
      checks++;
      if (out_q[1].nar !== 1'b0 || out_q[1].data !== 29'h1000) begin
        errors++; $display("FAIL nar_next_window: nar=%b data=%h, required 0 00001000",
                           out_q[1].nar, out_q[1].data);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    out_q.delete();
    for (int i = 0; i < 1024; i++) send_beat(mk(i == 0, i == 1023, 0, 32, 6, 0, 0));
    wait_outs(1, 0, ok);
    checks++;
    if (!ok || out_q.size() != 1) begin
      errors++; $display("FAIL ovf_beats: got %0d beats, required 1", out_q.size());
    end else begin
      checks++;
      if (out_q[0].data !== 29'h1000_0000 || out_q[0].ovf !== 1'b1 || out_q[0].sign !== 1'b1) begin
        errors++; $display("FAIL ovf_result: data=%h ovf=%b sign=%b, required 10000000 1 1",
                           out_q[0].data, out_q[0].ovf, out_q[0].sign);
      end
    end
  endtask

  task automatic test_hold_skid();
    bit ok;
    logic [28:0] held;
    out_q.delete();
    rtr_hold = 1'b0;
    send_beat(mk(1, 1, 0, 32, 0, 0, 0));
    send_beat(mk(1, 1, 0, 32, 1, 0, 0));
    send_beat(mk(1, 1, 0, 32, 2, 0, 0));
    repeat (6) @(posedge clk);
    #1;
    held = data_o;
    checks++;
    if (rts_o !== 1'b1 || held !== 29'h1000) begin
      errors++; $display("FAIL hold_output: rts=%b data=%h, required 1 00001000", rts_o, held);
    end
    rtr_hold = 1'b1;
    wait_outs(3, 0, ok);
    checks++;
    if (out_q.size() != 3) begin
      errors++; $display("FAIL skid_beats: got %0d beats, required 3", out_q.size());
    end else begin
      checks++;
      if (out_q[0].data !== 29'h1000 || out_q[1].data !== 29'h2000 || out_q[2].data !== 29'h4000) begin
        errors++; $display("FAIL skid_order: got %h %h %h, required 00001000 00002000 00004000",
                           out_q[0].data, out_q[1].data, out_q[2].data);
      end
    end
  endtask

  task automatic test_random_backpressure();
    beat_t win[$];
    beat_t b;
    logic [28:0] exp_d[$];
    bit exp_n[$];
    bit exp_v[$];
    logic [28:0] d;
    bit n, v, ok;
    int total, len;
    total = 0;
    out_q.delete();
    rtr_rand = 1'b1;
    while (total < 200) begin
      len = int'($urandom_range(1, 12));
      win.delete();
      for (int i = 0; i < len; i++) begin
        b.sow   = (i == 0);
        b.eow   = (i == len - 1);
        b.sign  = 1'($urandom_range(0, 1));
        b.mant  = int'($urandom_range(32, 63));
        b.scale = int'($urandom_range(0, 15)) - 8;
        b.zero  = ($urandom_range(0, 15) == 0);
        b.nar   = ($urandom_range(0, 31) == 0);
        win.push_back(b);
      end
      model_window(win, d, n, v);
      exp_d.push_back(d); exp_n.push_back(n); exp_v.push_back(v);
      foreach (win[i]) send_beat(win[i]);
      total += len;
    end
    wait_outs(exp_d.size(), 0, ok);
    rtr_rand = 1'b0;
    checks++;
    if (out_q.size() != exp_d.size()) begin
      errors++; $display("FAIL rand_beats: got %0d beats, required %0d", out_q.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i].data !== exp_d[i] || out_q[i].nar !== exp_n[i] || out_q[i].ovf !== exp_v[i]
          || out_q[i].zero !== (exp_d[i] == 0)) begin
        errors++; $display("FAIL rand_window_%0d: data=%h nar=%b ovf=%b zero=%b, required %h %b %b %b",
                           i, out_q[i].data, out_q[i].nar, out_q[i].ovf, out_q[i].zero,
                           exp_d[i], exp_n[i], exp_v[i], exp_d[i] == 0);
      end
    end
  endtask

  task automatic test_running_and_reset();
    bit ok;
    out_q.delete();
    out0_q.delete();
    send_beat(mk(1, 0, 0, 32, 0, 0, 0));
    send_beat(mk(0, 1, 0, 32, 0, 0, 0));
    wait_outs(2, 1, ok);
    checks++;
    if (out0_q.size() != 2) begin
      errors++; $display("FAIL running_beats: got %0d beats, required 2", out0_q.size());
    end else begin
      checks++;
      if (out0_q[0].data !== 29'h1000 || out0_q[0].sow !== 1'b1 || out0_q[0].eow !== 1'b0) begin
        errors++; $display("FAIL running_first: data=%h sow=%b eow=%b, required 00001000 1 0",
                           out0_q[0].data, out0_q[0].sow, out0_q[0].eow);
      end
      checks++;
      if (out0_q[1].data !== 29'h2000 || out0_q[1].sow !== 1'b0 || out0_q[1].eow !== 1'b1) begin
        errors++; $display("FAIL running_second: data=%h sow=%b eow=%b, required 00002000 0 1",
                           out0_q[1].data, out0_q[1].sow, out0_q[1].eow);
      end
    end
    rtr_hold = 1'b0;
    send_beat(mk(1, 0, 0, 32, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rts_o0 !== 1'b1) begin
      errors++; $display("FAIL running_pending: rts=%b, required 1", rts_o0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rtr_o0, rts_o0, sow_o0, eow_o0, data_o0, NaR_o0, sign_o0, zero_o0, ovf_o0,
         rtr_o, rts_o, data_o} !== '0) begin
      errors++; $display("FAIL midreset_outputs: rts0=%b data0=%h rtr0=%b rts=%b, required all 0",
                         rts_o0, data_o0, rtr_o0, rts_o);
    end
    rtr_hold = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    out_q.delete();
    send_beat(mk(0, 1, 0, 32, 0, 0, 0));
    wait_outs(1, 0, ok);
    checks++;
    if (out_q.size() != 1 || out_q[0].data !== 29'h1000) begin
      errors++; $display("FAIL midreset_discard: beats=%0d data=%h, required 1 00001000",
                         out_q.size(), out_q.size() > 0 ? out_q[0].data : 29'h0);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_single();
    test_nar();
    test_overflow();
    test_hold_skid();
    test_random_backpressure();
    test_running_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
